// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: PS/2 keyboard frame receiver and arrow/letter key decoder
// that turns held left/right keys into signed paddle steps on each movement tick.
module paddle_input_ctrl #(
   parameter int         SPEED   = 1,
   parameter int         TIMEOUT = 5000,
   parameter logic [2:0] PLAY    = 3'b001
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   input  logic       tick,
   input  logic [2:0] state,
   output logic [7:0] paddleIn,
   output logic       inEnable,
   output logic       leftHeld,
   output logic       rightHeld
);
   localparam int             TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TO_MAX = TW'(TIMEOUT);
   localparam logic [7:0]     STEP   = 8'(SPEED);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_t;

   frame_t        r_fsm;
   logic [2:0]    r_clk_s;
   logic [1:0]    r_dat_s;
   logic [7:0]    r_shift;
   logic [7:0]    r_byte;
   logic [2:0]    r_bit;
   logic [TW-1:0] r_to;
   logic          r_par;
   logic          r_byte_valid;
   logic          r_ext;
   logic          r_brk;
   logic          r_left;
   logic          r_right;
   logic          r_tick_d;
   logic          r_en;
   logic [7:0]    r_paddle;

   logic w_fall, w_bit, w_e0, w_f0, w_key, w_is_l, w_is_r, w_left_n, w_right_n, w_move;

   // r_clk_s[2] is the delayed copy of the second sync flop, giving the edge detector
   assign w_fall    = r_clk_s[2] & ~r_clk_s[1];
   assign w_bit     = r_dat_s[1];
   assign w_e0      = r_byte == 8'hE0;
   assign w_f0      = r_byte == 8'hF0;
   assign w_key     = r_byte_valid & ~w_e0 & ~w_f0;
   assign w_is_l    = r_ext ? (r_byte == 8'h6B) : (r_byte == 8'h1C);
   assign w_is_r    = r_ext ? (r_byte == 8'h74) : (r_byte == 8'h23);
   assign w_left_n  = (w_key & w_is_l) ? ~r_brk : r_left;
   assign w_right_n = (w_key & w_is_r) ? ~r_brk : r_right;
   // the tick sees flags already updated by a byte decoded in the same cycle
   assign w_move    = tick & ~r_tick_d & (state == PLAY) & (w_left_n ^ w_right_n);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_fsm        <= IDLE;
         r_clk_s      <= '1;
         r_dat_s      <= '1;
         r_shift      <= '0;
         r_byte       <= '0;
         r_bit        <= '0;
         r_to         <= '0;
         r_par        <= 1'b0;
         r_byte_valid <= 1'b0;
      end else begin
         r_clk_s      <= {r_clk_s[1:0], ps2_clk};
         r_dat_s      <= {r_dat_s[0], ps2_dat};
         r_byte_valid <= 1'b0;
         r_to         <= (r_fsm == IDLE || w_fall) ? '0 : r_to + TW'(1);
         if (r_fsm != IDLE && !w_fall && r_to == TO_MAX)
            r_fsm <= IDLE;
         else if (w_fall)
            case (r_fsm)
               IDLE: if (!w_bit) begin
                  r_fsm <= DATA;
                  r_bit <= '0;
               end
               DATA: begin
                  r_shift <= {w_bit, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  r_fsm   <= (r_bit == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  r_par <= w_bit;
                  r_fsm <= STOP;
               end
               default: begin
                  r_fsm <= IDLE;
                  if (w_bit && ^{r_shift, r_par}) begin
                     r_byte_valid <= 1'b1;
                     r_byte       <= r_shift;
                  end
               end
            endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_ext    <= 1'b0;
         r_brk    <= 1'b0;
         r_left   <= 1'b0;
         r_right  <= 1'b0;
         r_tick_d <= 1'b0;
         r_en     <= 1'b0;
         r_paddle <= '0;
      end else begin
         r_ext    <= r_byte_valid ? (w_e0 | (w_f0 & r_ext)) : r_ext;
         r_brk    <= r_byte_valid ? (w_f0 | (w_e0 & r_brk)) : r_brk;
         r_left   <= w_left_n;
         r_right  <= w_right_n;
         r_tick_d <= tick;
         r_en     <= w_move;
         r_paddle <= w_move ? (w_left_n ? -STEP : STEP) : r_paddle;
      end
   end

   assign paddleIn  = r_paddle;
   assign inEnable  = r_en;
   assign leftHeld  = r_left;
   assign rightHeld = r_right;
endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: randomized PS/2 keystrokes and ticks against a byte-level
// key model; a queue scoreboard checks every inEnable strobe and held paddle value.
module tb_paddle_input_ctrl;
   localparam int         SPEED   = 1;
   localparam int         TIMEOUT = 300;
   localparam logic [2:0] PLAY    = 3'b001;

   logic       clock = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1, tick = 1'b0;
   logic [2:0] state = PLAY;
   logic [7:0] paddleIn;
   logic       inEnable, leftHeld, rightHeld;

   paddle_input_ctrl #(.SPEED(SPEED), .TIMEOUT(TIMEOUT), .PLAY(PLAY)) dut (
      .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .tick(tick), .state(state), .paddleIn(paddleIn), .inEnable(inEnable),
      .leftHeld(leftHeld), .rightHeld(rightHeld));

   always #5 clock = ~clock;

   int         n_cmp = 0, n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_pad = 8'h00;
   logic       prev_en = 1'b0;
   bit         m_left, m_right, m_ext, m_brk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // key model works on whole accepted bytes
   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (b == (m_ext ? 8'h6B : 8'h1C)) m_left = !m_brk;
         if (b == (m_ext ? 8'h74 : 8'h23)) m_right = !m_brk;
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic model_reset();
      m_left = 0; m_right = 0; m_ext = 0; m_brk = 0;
      exp_q.delete();
      last_pad = 8'h00;
      prev_en = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                             input int nbits = 11);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = f[i];
         wait_cyc(10);
         ps2_clk = 1'b0;
         wait_cyc(10);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      wait_cyc(12);
      if (nbits == 11) begin
         if (!bad_par && !bad_stop) model_byte(b);
         check("leftHeld", leftHeld, m_left);
         check("rightHeld", rightHeld, m_right);
      end
   endtask

   task automatic do_tick(input logic [2:0] st, input int len);
      state = st;
      wait_cyc(1);
      tick = 1'b1;
      if (st == PLAY && (m_left ^ m_right)) exp_q.push_back(m_left ? 8'(-SPEED) : 8'(SPEED));
      wait_cyc(len);
      tick = 1'b0;
      wait_cyc(3);
   endtask

   always @(negedge clock) begin
      if (resetn) begin
         if (inEnable) begin
            check("en_twice", prev_en, 1'b0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_move: got inEnable=1 paddleIn=%0h expected no strobe", paddleIn);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               check("paddleIn", paddleIn, e);
               last_pad = e;
            end
         end else check("paddle_hold", paddleIn, last_pad);
         prev_en = inEnable;
      end
   end

   initial begin
      logic [7:0] code;
      bit         x, k, lr;
      model_reset();
      wait_cyc(3);
      check("rst_paddleIn", paddleIn, 8'h00);
      check("rst_inEnable", inEnable, 1'b0);
      check("rst_left", leftHeld, 1'b0);
      check("rst_right", rightHeld, 1'b0);
      resetn = 1'b1;
      wait_cyc(3);
      // left press then movement
      send_frame(8'h1C);
      do_tick(PLAY, 1);
      send_frame(8'hF0);
      send_frame(8'h1C);
      // corrupted frames leave flags alone
      send_frame(8'h23, 1, 0);
      send_frame(8'h23, 0, 1);
      // extended right press, move, then release
      send_frame(8'hE0);
      send_frame(8'h74);
      do_tick(PLAY, 1);
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'h74);
      do_tick(PLAY, 1);
      // abandoned partial frame
      send_frame(8'h55, 0, 0, 5);
      wait_cyc(TIMEOUT + 1);
      send_frame(8'h1C);
      // state gating and held tick
      do_tick(3'b000, 1);
      do_tick(PLAY, 1);
      do_tick(PLAY, 4);
      // random traffic
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 6))
            0, 1: begin
               x = 1'($urandom_range(0, 1)); k = 1'($urandom_range(0, 1)); lr = 1'($urandom_range(0, 1));
               code = x ? (lr ? 8'h74 : 8'h6B) : (lr ? 8'h23 : 8'h1C);
               if (x) send_frame(8'hE0);
               if (k) send_frame(8'hF0);
               send_frame(code);
            end
            2: send_frame(8'($urandom));
            3: begin
               x = 1'($urandom_range(0, 1));
               send_frame(8'($urandom), x, !x);
            end
            4: begin
               send_frame(8'($urandom), 0, 0, $urandom_range(1, 10));
               wait_cyc(TIMEOUT + 20);
            end
            default: do_tick($urandom_range(0, 1) ? PLAY : 3'($urandom_range(2, 7)), $urandom_range(1, 4));
         endcase
      end
      wait_cyc(5);
      check("queue_drained", exp_q.size(), 0);
      // reset mid-frame with right held
      send_frame(8'hF0);
      send_frame(8'h1C);
      send_frame(8'h23);
      do_tick(PLAY, 1);
      send_frame(8'h1C, 0, 0, 5);
      check("pre_rst_right", rightHeld, 1'b1);
      resetn = 1'b0;
      #1;
      check("arst_paddleIn", paddleIn, 8'h00);
      check("arst_inEnable", inEnable, 1'b0);
      check("arst_left", leftHeld, 1'b0);
      check("arst_right", rightHeld, 1'b0);
      model_reset();
      wait_cyc(3);
      resetn = 1'b1;
      wait_cyc(2);
      do_tick(PLAY, 1);
      send_frame(8'h1C);
      do_tick(PLAY, 1);
      wait_cyc(5);
      check("final_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/paddle_input_ctrl.md
PADDLE_INPUT_CTRL -- requirements
Module: paddle_input_ctrl

Interface
REQ-001 Parameter SPEED, default 1: paddle step magnitude per movement tick, 1..127.
REQ-002 Parameter TIMEOUT, default 5000: clock cycles without a PS/2 falling edge before an in-progress frame is abandoned.
REQ-003 Parameter PLAY, default 3'b001: game-state code in which movement is emitted.
REQ-004 clock  in  1  system clock, all state on rising edge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 ps2_clk  in  1  raw PS/2 keyboard clock, asynchronous to clock.
REQ-007 ps2_dat  in  1  raw PS/2 keyboard data, asynchronous to clock.
REQ-008 tick  in  1  one-cycle movement-rate strobe.
REQ-009 state  in  3  current game state.
REQ-010 paddleIn  out  8  signed two's-complement paddle delta, drives paddle "in".
REQ-011 inEnable  out  1  one-cycle strobe qualifying paddleIn, drives paddle "inEnable".
REQ-012 leftHeld, rightHeld  out  1 each  current key-held flags, debug visibility.

Function
REQ-013 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; a falling edge is a synchronized 1->0 transition, detected one cycle after the second flop.
REQ-014 Frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on falling edge with data 0 (start bit) -> DATA, bit counter cleared; start bit 1 stays IDLE.
REQ-016 DATA: each falling edge shifts data in LSB-first; after the 8th bit -> PARITY.
REQ-017 PARITY: on falling edge, capture parity bit -> STOP.
REQ-018 STOP: on falling edge -> IDLE; byte accepted only if stop bit is 1 and data+parity has odd count of ones; otherwise discarded silently.
REQ-019 Accepted byte SHALL produce an internal one-cycle byteValid on the cycle after the stop edge.
REQ-020 Timeout counter SHALL clear on every falling edge and in IDLE; reaching TIMEOUT in DATA, PARITY or STOP -> IDLE, partial frame discarded, prefix flags unchanged.
REQ-021 Byte 8'hE0 SHALL set ext flag; byte 8'hF0 SHALL set brk flag; both flags persist until next non-prefix byte.
REQ-022 Non-prefix byte: left key = (ext & 8'h6B) or (!ext & 8'h1C); right key = (ext & 8'h74) or (!ext & 8'h23); matching key flag set to !brk; any other code leaves key flags unchanged; ext and brk cleared in all cases.
REQ-023 Output stage: on tick with state==PLAY, exactly one of leftHeld/rightHeld set -> paddleIn = -SPEED (left) or +SPEED (right), inEnable=1 on the following cycle only.
REQ-024 tick with both or neither held, or state!=PLAY -> inEnable stays 0, paddleIn holds previous value.
REQ-025 Key flags SHALL track keyboard in every state, so a key held across a state change produces movement immediately on the first PLAY tick.
REQ-026 byteValid and tick in the same cycle: flag update applies first; the tick uses updated flags.
REQ-027 inEnable SHALL never be high two consecutive cycles, even with tick held high; tick is edge-treated (rising only).

Reset
REQ-028 resetn low SHALL asynchronously force: FSM IDLE, shift/bit/timeout counters 0, synchronizers 1, ext=brk=0, leftHeld=rightHeld=0, paddleIn=8'h00, inEnable=0.
REQ-029 Reset mid-frame SHALL discard the frame; first byte after release is decoded only from a fresh start bit.

Verification
REQ-030 Send frame 8'h1C (parity 0, stop 1), state=PLAY, pulse tick -> leftHeld=1, next cycle paddleIn=8'hFF, inEnable=1 for one cycle.
REQ-031 Send E0,74 then tick; then E0,F0,74 then tick -> first paddleIn=8'h01 inEnable=1; second rightHeld=0, inEnable stays 0.
REQ-032 Send 8'h23 with bad parity bit -> no flag change; send with stop bit 0 -> no flag change.
REQ-033 Send 4 data bits then idle TIMEOUT+1 cycles, then full 8'h1C frame -> only 8'h1C decoded, leftHeld=1.
REQ-034 Hold left, state=3'b000, pulse tick -> inEnable 0; set state=3'b001, pulse tick -> paddleIn=8'hFF, inEnable=1.
REQ-035 Assert resetn=0 mid-frame with rightHeld=1 -> all outputs 0 immediately; after release, next tick gives inEnable 0.
